// File: rtl/split_data.sv
// split_data: unpacks wide memory words into a narrow MSB-first pixel stream.
// Pixels may straddle word boundaries; LINE mode drops the residue at each line end.
module split_data #(
    parameter int ISIZE = 24,
    parameter int OSIZE = 256,
    parameter     MODE  = "LINE"
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             ivalid,
    output logic             iready,
    input  logic [OSIZE-1:0] idata,
    input  logic             ilast,
    input  logic             ialign,
    output logic             ovalid,
    input  logic             oready,
    output logic [ISIZE-1:0] odata,
    output logic             olast
);
    localparam int BW = OSIZE + ISIZE;
    localparam int CW = $clog2(BW + 1);
    localparam logic [CW-1:0] ONE_PIX   = CW'(ISIZE);
    localparam logic [CW-1:0] TWO_PIX   = CW'(2 * ISIZE);
    localparam logic [CW-1:0] WORD_BITS = CW'(OSIZE);
    localparam bit LINE_MODE = (MODE == "LINE");

    logic [BW-1:0] data_buf;
    logic [BW-1:0] buf_shifted;
    logic [BW-1:0] buf_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_shifted;
    logic [CW-1:0] cnt_next;
    logic          lpend;
    logic          lpend_next;
    logic          pop;
    logic          push;

    assign ovalid = (cnt >= ONE_PIX);
    assign odata  = data_buf[BW-1 -: ISIZE];
    assign olast  = LINE_MODE && lpend && (cnt < TWO_PIX) && ovalid;
    assign pop    = ovalid && oready;
    // A word is taken only once the bits left after this cycle's pop cannot form a pixel.
    assign iready = !ialign && !lpend && ((cnt < ONE_PIX) || ((cnt < TWO_PIX) && pop));
    assign push   = ivalid && iready;

    always_comb begin
        buf_shifted = data_buf;
        cnt_shifted = cnt;
        lpend_next  = lpend;
        if (pop && olast) begin
            buf_shifted = '0;
            cnt_shifted = '0;
            lpend_next  = 1'b0;
        end else if (pop) begin
            buf_shifted = data_buf << ISIZE;
            cnt_shifted = cnt - ONE_PIX;
        end

        buf_next = buf_shifted;
        cnt_next = cnt_shifted;
        // Bits below the valid region are always zero, so OR-ing places the new word.
        if (push) begin
            buf_next = buf_shifted | ({idata, {ISIZE{1'b0}}} >> cnt_shifted);
            cnt_next = cnt_shifted + WORD_BITS;
            if (LINE_MODE && ilast) begin
                lpend_next = 1'b1;
            end
        end

        if (ialign) begin
            buf_next   = '0;
            cnt_next   = '0;
            lpend_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_buf <= '0;
            cnt      <= '0;
            lpend    <= 1'b0;
        end else begin
            data_buf <= buf_next;
            cnt      <= cnt_next;
            lpend    <= lpend_next;
        end
    end

endmodule

// File: tb/tb_split_data.sv
// tb_split_data: drives a LINE/24-bit and a ONCE/32-bit split_data against
// a bit-queue reference model of the MSB-first pixel stream.
`timescale 1ns/1ps
module tb_split_data;
    localparam int OSIZE = 256;
    localparam int ISA   = 24;
    localparam int ISC   = 32;
    typedef logic [OSIZE-1:0] word_t;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    always #5 clock = ~clock;

    logic             a_ivalid = 1'b0;
    logic             a_iready;
    logic [OSIZE-1:0] a_idata  = '0;
    logic             a_ilast  = 1'b0;
    logic             a_ialign = 1'b0;
    logic             a_ovalid;
    logic             a_oready = 1'b0;
    logic [ISA-1:0]   a_odata;
    logic             a_olast;

    logic             c_ivalid = 1'b0;
    logic             c_iready;
    logic [OSIZE-1:0] c_idata  = '0;
    logic             c_ilast  = 1'b0;
    logic             c_ialign = 1'b0;
    logic             c_ovalid;
    logic             c_oready = 1'b0;
    logic [ISC-1:0]   c_odata;
    logic             c_olast;

    split_data #(.ISIZE(ISA), .OSIZE(OSIZE), .MODE("LINE")) u_line (
        .clock(clock), .rst_n(rst_n), .ivalid(a_ivalid), .iready(a_iready),
        .idata(a_idata), .ilast(a_ilast), .ialign(a_ialign), .ovalid(a_ovalid),
        .oready(a_oready), .odata(a_odata), .olast(a_olast)
    );

    split_data #(.ISIZE(ISC), .OSIZE(OSIZE), .MODE("ONCE")) u_once (
        .clock(clock), .rst_n(rst_n), .ivalid(c_ivalid), .iready(c_iready),
        .idata(c_idata), .ilast(c_ilast), .ialign(c_ialign), .ovalid(c_ovalid),
        .oready(c_oready), .odata(c_odata), .olast(c_olast)
    );

    int checks = 0;
    int errors = 0;
    int a_rate = 100;
    int c_rate = 100;
    int a_pops = 0;
    int a_lasts = 0;
    int c_pops = 0;
    bit a_q[$];
    bit a_pend = 1'b0;
    bit c_q[$];

    task automatic checkOutput(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clock);
        #1;
        a_oready = ($urandom_range(99) < a_rate);
        c_oready = ($urandom_range(99) < c_rate);
    end

    // Reference for the LINE instance: pending bits form one MSB-first queue.
    always @(negedge clock) begin : mon_a
        int n;
        logic [ISA-1:0] head;
        bit exp_last;
        bit pop;
        bit exp_ready;
        if (!rst_n) begin
            a_q.delete();
            a_pend = 1'b0;
        end else begin
            n = a_q.size();
            head = '0;
            for (int i = 0; i < ISA; i++) if (i < n) head[ISA-1-i] = a_q[i];
            exp_last = a_pend && (n >= ISA) && (n < 2 * ISA);
            checkOutput("a_ovalid", word_t'(a_ovalid), word_t'(n >= ISA));
            if (n >= ISA) begin
                checkOutput("a_odata", word_t'(a_odata), word_t'(head));
                checkOutput("a_olast", word_t'(a_olast), word_t'(exp_last));
            end
            pop = (n >= ISA) && a_oready && !a_ialign;
            exp_ready = !a_ialign && !a_pend && ((pop ? n - ISA : n) < ISA);
            checkOutput("a_iready", word_t'(a_iready), word_t'(exp_ready));
            if (a_ialign) begin
                a_q.delete();
                a_pend = 1'b0;
            end else begin
                if (pop) begin
                    a_pops++;
                    if (exp_last) begin
                        a_lasts++;
                        a_q.delete();
                        a_pend = 1'b0;
                    end else begin
                        repeat (ISA) void'(a_q.pop_front());
                    end
                end
                if (a_ivalid && a_iready) begin
                    for (int i = OSIZE - 1; i >= 0; i--) a_q.push_back(a_idata[i]);
                    if (a_ilast) a_pend = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin : mon_c
        int n;
        logic [ISC-1:0] head;
        bit pop;
        if (!rst_n) begin
            c_q.delete();
        end else begin
            n = c_q.size();
            head = '0;
            for (int i = 0; i < ISC; i++) if (i < n) head[ISC-1-i] = c_q[i];
            checkOutput("c_ovalid", word_t'(c_ovalid), word_t'(n >= ISC));
            checkOutput("c_olast", word_t'(c_olast), word_t'(0));
            if (n >= ISC) checkOutput("c_odata", word_t'(c_odata), word_t'(head));
            pop = (n >= ISC) && c_oready;
            checkOutput("c_iready", word_t'(c_iready), word_t'((pop ? n - ISC : n) < ISC));
            if (pop) begin
                c_pops++;
                repeat (ISC) void'(c_q.pop_front());
            end
            if (c_ivalid && c_iready) begin
                for (int i = OSIZE - 1; i >= 0; i--) c_q.push_back(c_idata[i]);
            end
        end
    end

    task automatic applyStimulus(input int inst, input word_t word, input bit last);
        int cyc;
        bit accepted;
        @(posedge clock);
        #1;
        if (inst == 0) begin
            a_ivalid = 1'b1; a_idata = word; a_ilast = last;
        end else begin
            c_ivalid = 1'b1; c_idata = word;
        end
        cyc = 0;
        accepted = 1'b0;
        while (!accepted && cyc < 500) begin
            @(negedge clock);
            accepted = (inst == 0) ? a_iready : c_iready;
            cyc++;
        end
        checkOutput("accept", word_t'(accepted), word_t'(1));
        @(posedge clock);
        #1;
        a_ivalid = 1'b0; a_ilast = 1'b0;
        c_ivalid = 1'b0;
    endtask

    task automatic waitDrain(input int inst);
        int idle = 0;
        int cyc = 0;
        while (idle < 4 && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            if (((inst == 0) ? a_ovalid : c_ovalid) == 1'b0) idle++;
            else idle = 0;
        end
        checkOutput("drain", word_t'(idle >= 4), word_t'(1));
    endtask

    task automatic waitPops(input int target);
        int cyc = 0;
        while (a_pops < target && cyc < 1000) begin
            @(posedge clock);
            cyc++;
        end
        checkOutput("pop_wait", word_t'(a_pops >= target), word_t'(1));
    endtask

    function automatic word_t randWord();
        word_t w;
        for (int i = 0; i < OSIZE / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        word_t w;
        bit sq[$];
        logic [ISA-1:0] top;
        int base;
        int lbase;

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_ovalid", word_t'(a_ovalid), word_t'(0));
        checkOutput("rst_odata", word_t'(a_odata), word_t'(0));
        checkOutput("rst_olast", word_t'(a_olast), word_t'(0));
        checkOutput("rst_iready", word_t'(a_iready), word_t'(1));
        checkOutput("rst_c_ovalid", word_t'(c_ovalid), word_t'(0));
        checkOutput("rst_c_iready", word_t'(c_iready), word_t'(1));
        rst_n = 1'b1;

        // Counting pixels 0..31 packed into three words.
        a_rate = 100;
        sq.delete();
        for (int p = 0; p < 32; p++) for (int b = ISA - 1; b >= 0; b--) sq.push_back(p[b]);
        base = a_pops;
        for (int k = 0; k < 3; k++) begin
            for (int b = OSIZE - 1; b >= 0; b--) w[b] = sq.pop_front();
            applyStimulus(0, w, 1'b0);
        end
        waitDrain(0);
        checkOutput("t1_count", word_t'(a_pops - base), word_t'(32));

        // Line end after two words: 21 pixels, residue dropped.
        base = a_pops;
        lbase = a_lasts;
        applyStimulus(0, randWord(), 1'b0);
        applyStimulus(0, randWord(), 1'b1);
        waitDrain(0);
        checkOutput("t2_count", word_t'(a_pops - base), word_t'(21));
        checkOutput("t2_lasts", word_t'(a_lasts - lbase), word_t'(1));
        w = randWord();
        top = w[OSIZE-1 -: ISA];
        applyStimulus(0, w, 1'b1);
        checkOutput("t2_w3_valid", word_t'(a_ovalid), word_t'(1));
        checkOutput("t2_w3_first", word_t'(a_odata), word_t'(top));
        waitDrain(0);

        // Random backpressure over 20 words of a counting stream.
        a_rate = 50;
        sq.delete();
        for (int p = 0; p < 214; p++) for (int b = ISA - 1; b >= 0; b--) sq.push_back(p[b]);
        base = a_pops;
        for (int k = 0; k < 20; k++) begin
            for (int b = OSIZE - 1; b >= 0; b--) w[b] = sq.pop_front();
            applyStimulus(0, w, 1'b0);
        end
        waitDrain(0);
        checkOutput("t3_count", word_t'(a_pops - base), word_t'(213));

        // Flush after four pixels of a word.
        a_rate = 100;
        base = a_pops;
        applyStimulus(0, randWord(), 1'b0);
        waitPops(base + 4);
        #1 a_ialign = 1'b1;
        @(posedge clock);
        #1 a_ialign = 1'b0;
        checkOutput("t4_flush_ovalid", word_t'(a_ovalid), word_t'(0));
        w = randWord();
        top = w[OSIZE-1 -: ISA];
        applyStimulus(0, w, 1'b0);
        checkOutput("t4_first", word_t'(a_odata), word_t'(top));
        waitDrain(0);

        // Asynchronous reset in the middle of a word.
        base = a_pops;
        applyStimulus(0, randWord(), 1'b0);
        waitPops(base + 3);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_ovalid", word_t'(a_ovalid), word_t'(0));
        checkOutput("t6_odata", word_t'(a_odata), word_t'(0));
        checkOutput("t6_olast", word_t'(a_olast), word_t'(0));
        checkOutput("t6_iready", word_t'(a_iready), word_t'(1));
        @(posedge clock);
        #1 rst_n = 1'b1;
        w = randWord();
        top = w[OSIZE-1 -: ISA];
        applyStimulus(0, w, 1'b0);
        checkOutput("t6_first", word_t'(a_odata), word_t'(top));
        waitDrain(0);

        // 32-bit pixels: exactly eight per word, with and without backpressure.
        c_rate = 100;
        base = c_pops;
        for (int k = 0; k < 4; k++) applyStimulus(1, randWord(), 1'b0);
        waitDrain(1);
        checkOutput("t5_count", word_t'(c_pops - base), word_t'(32));
        c_rate = 50;
        base = c_pops;
        for (int k = 0; k < 6; k++) applyStimulus(1, randWord(), 1'b0);
        waitDrain(1);
        checkOutput("t5_count_bp", word_t'(c_pops - base), word_t'(48));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
